// File: rtl/aes_key_expand.sv
// aes_key_expand: sequential AES key schedule (AES-128/192/256 selected by NK).
// Expands key_in into the word stream w[0..NW-1] and emits one 32-bit word per
// accepted valid/ready handshake. Round constants come from an xtime register.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, key_in   begin expansion of key_in (sampled only in IDLE)
//   busy, done      run in progress / one-cycle completion pulse
//   w_valid/w_ready word stream handshake
//   w_out, w_index  current schedule word and its index
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for start, outputs quiet
// RUN   | presenting w[w_index], advancing on handshake
// DONE  | one-cycle completion pulse, then back to IDLE

module sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 = prod of x^(2^k), k=1..7; maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = x;
    res = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      res = gmul(res, sq);
    end
    return res;
  endfunction

  logic [7:0] w_inv;

  always_comb begin
    w_inv  = ginv(i_byte);
    o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_expand #(
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [32*NK-1:0] key_in,
  output logic             busy,
  output logic             w_valid,
  input  logic             w_ready,
  output logic [31:0]      w_out,
  output logic [5:0]       w_index,
  output logic             done
);
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam int PW = $clog2(NK);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_win [NK];
  logic [7:0]      r_rcon;
  logic [5:0]      r_idx;
  logic [PW-1:0]   r_phase;

  logic            w_hs;
  logic            w_last;
  logic            w_in_key;
  logic [31:0]     w_t;
  logic [31:0]     w_sub_in;
  logic [31:0]     w_sub;
  logic [31:0]     w_f;
  logic [31:0]     w_word;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_hs && w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_hs     = (r_state == S_RUN) && w_ready;
  assign w_last   = (r_idx == 6'(NW - 1));
  assign w_in_key = (r_idx < 6'(NK));

  // Window holds w[i-NK..i-1]: r_win[0] is the oldest, r_win[NK-1] the newest.
  assign w_t      = r_win[NK-1];
  assign w_sub_in = (r_phase == '0) ? {w_t[23:0], w_t[31:24]} : w_t;

  for (genvar g = 0; g < 4; g++) begin : g_sub
    sbox u_sbox (
      .i_byte(w_sub_in[8*g +: 8]),
      .o_byte(w_sub[8*g +: 8])
    );
  end

  always_comb begin
    w_f = w_t;
    if (r_phase == '0)
      w_f = w_sub ^ {r_rcon, 24'h000000};
    else if (NK == 8 && int'(r_phase) == 4)
      w_f = w_sub;
  end

  // While i<NK the window is still the raw key, indexed directly by the phase.
  assign w_word = w_in_key ? r_win[r_phase] : (r_win[0] ^ w_f);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NK; k++) r_win[k] <= '0;
      r_rcon  <= 8'h01;
      r_idx   <= '0;
      r_phase <= '0;
    end else if (r_state == S_IDLE && start) begin
      for (int k = 0; k < NK; k++) r_win[k] <= key_in[32*(NK-k)-1 -: 32];
      r_rcon  <= 8'h01;
      r_idx   <= '0;
      r_phase <= '0;
    end else if (w_hs) begin
      if (!w_last) begin
        r_idx   <= r_idx + 6'd1;
        r_phase <= (r_phase == PW'(NK - 1)) ? '0 : r_phase + 1'b1;
      end
      if (!w_in_key) begin
        for (int k = 0; k < NK - 1; k++) r_win[k] <= r_win[k+1];
        r_win[NK-1] <= w_word;
        if (r_phase == '0) r_rcon <= xtime(r_rcon);
      end
    end
  end

  assign busy    = (r_state == S_RUN);
  assign w_valid = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign w_index = r_idx;
  assign w_out   = (r_state == S_RUN) ? w_word : 32'h0;
endmodule
